// File: rtl/fc_word_aligner.sv
// fc_word_aligner: fast-command word aligner and decoder.
// Locks the 8-bit frame boundary onto the IDLE pattern, emits aligned words
// with a one-cycle valid pulse and one-cycle command strobes, and tracks lock,
// boundary slips and (optionally) invalid words seen while locked.
//
// Build option: define FC_ERRCNT_EN to implement the err_cnt counter;
// otherwise err_cnt is tied to zero.
//
// state   | meaning
// --------+--------------------------------------------------------------
// SEARCH  | hunting for the boundary; non-IDLE words slip it one bit earlier
// LOCKED  | boundary fixed; valid words raise strobes, bad runs drop lock

module fc_word_aligner #(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4
) (
    input  logic       clk320,
    input  logic       rst320,
    input  logic       enable,
    input  logic       fc,
    output logic [7:0] fc_word,
    output logic       fc_word_valid,
    output logic       locked,
    output logic [3:0] slip_cnt,
    output logic [7:0] err_cnt,
    output logic       cmd_idle,
    output logic       cmd_linkrst,
    output logic       cmd_bcr,
    output logic       cmd_sync,
    output logic       cmd_l1a,
    output logic       cmd_l1a_cr,
    output logic       cmd_chginj,
    output logic       cmd_l1a_bcr
);

    localparam logic ST_SEARCH = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    localparam logic [7:0] CODE_IDLE    = 8'hF0;
    localparam logic [7:0] CODE_LINKRST = 8'h33;
    localparam logic [7:0] CODE_BCR     = 8'h5A;
    localparam logic [7:0] CODE_SYNC    = 8'h55;
    localparam logic [7:0] CODE_L1A     = 8'h96;
    localparam logic [7:0] CODE_L1A_CR  = 8'h66;
    localparam logic [7:0] CODE_CHGINJ  = 8'h69;
    localparam logic [7:0] CODE_L1A_BCR = 8'h99;

    localparam logic [7:0] LOCK_LIM   = 8'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_LIM = 4'(UNLOCK_CNT);

    logic       state;
    logic [7:0] sreg;
    logic [2:0] bit_cnt;
    logic [7:0] good_cnt;
    logic [3:0] bad_cnt;
    logic [7:0] cmd_q;

    logic [7:0] word_next;
    logic [7:0] cmd_hit;
    logic       word_ok;
    logic       boundary;
    logic [7:0] good_inc;
    logic [3:0] bad_inc;

    assign word_next = {sreg[6:0], fc};
    assign boundary  = enable && (bit_cnt == 3'd7);
    assign good_inc  = good_cnt + 8'd1;
    assign bad_inc   = bad_cnt + 4'd1;

    // Decode the word completing this cycle into a one-hot command vector.
    always_comb begin
        cmd_hit = 8'h00;
        word_ok = 1'b1;
        case (word_next)
            CODE_IDLE:    cmd_hit[7] = 1'b1;
            CODE_LINKRST: cmd_hit[6] = 1'b1;
            CODE_BCR:     cmd_hit[5] = 1'b1;
            CODE_SYNC:    cmd_hit[4] = 1'b1;
            CODE_L1A:     cmd_hit[3] = 1'b1;
            CODE_L1A_CR:  cmd_hit[2] = 1'b1;
            CODE_CHGINJ:  cmd_hit[1] = 1'b1;
            CODE_L1A_BCR: cmd_hit[0] = 1'b1;
            default:      word_ok    = 1'b0;
        endcase
    end

    // Shift register, boundary counter, lock FSM and word/strobe outputs.
    always_ff @(posedge clk320) begin
        if (rst320) begin
            state         <= ST_SEARCH;
            sreg          <= 8'h00;
            bit_cnt       <= 3'd0;
            good_cnt      <= 8'd0;
            bad_cnt       <= 4'd0;
            slip_cnt      <= 4'd0;
            fc_word       <= 8'h00;
            fc_word_valid <= 1'b0;
            cmd_q         <= 8'h00;
        end else if (!enable) begin
            fc_word_valid <= 1'b0;
            cmd_q         <= 8'h00;
        end else begin
            sreg          <= word_next;
            bit_cnt       <= bit_cnt + 3'd1;
            fc_word_valid <= 1'b0;
            cmd_q         <= 8'h00;
            if (bit_cnt == 3'd7) begin
                fc_word       <= word_next;
                fc_word_valid <= 1'b1;
                if (state == ST_SEARCH) begin
                    if (word_next == CODE_IDLE) begin
                        good_cnt <= good_inc;
                        if (good_inc == LOCK_LIM) begin
                            state   <= ST_LOCKED;
                            bad_cnt <= 4'd0;
                            cmd_q   <= cmd_hit;
                        end
                    end else begin
                        // Restarting at 1 shortens the next word by one bit.
                        good_cnt <= 8'd0;
                        bit_cnt  <= 3'd1;
                        if (slip_cnt != 4'hF) begin
                            slip_cnt <= slip_cnt + 4'd1;
                        end
                    end
                end else begin
                    if (word_ok) begin
                        bad_cnt <= 4'd0;
                        cmd_q   <= cmd_hit;
                    end else begin
                        bad_cnt <= bad_inc;
                        // Unlock boundary keeps its alignment; no slip here.
                        if (bad_inc == UNLOCK_LIM) begin
                            state    <= ST_SEARCH;
                            good_cnt <= 8'd0;
                            bad_cnt  <= 4'd0;
                        end
                    end
                end
            end
        end
    end

`ifdef FC_ERRCNT_EN
    logic err_event;
    assign err_event = boundary && (state == ST_LOCKED) && !word_ok;

    // Count invalid words seen while locked, saturating at 255.
    always_ff @(posedge clk320) begin
        if (rst320) begin
            err_cnt <= 8'd0;
        end else if (err_event && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign err_cnt = 8'd0;
`endif

    assign locked      = (state == ST_LOCKED);
    assign cmd_idle    = cmd_q[7];
    assign cmd_linkrst = cmd_q[6];
    assign cmd_bcr     = cmd_q[5];
    assign cmd_sync    = cmd_q[4];
    assign cmd_l1a     = cmd_q[3];
    assign cmd_l1a_cr  = cmd_q[2];
    assign cmd_chginj  = cmd_q[1];
    assign cmd_l1a_bcr = cmd_q[0];

    // boundary is only consumed by the optional error counter.
    logic unused_ok;
    assign unused_ok = boundary;

endmodule

// File: tb/tb_fc_word_aligner.sv
// Testbench for fc_word_aligner: directed sequences, a table of command
// vectors, and randomized streams checked against a word-level model.
// Honours FC_ERRCNT_EN the same way as the design.

module tb_fc_word_aligner;

    localparam int LOCK_CNT   = 16;
    localparam int UNLOCK_CNT = 4;

    logic       clk320 = 1'b0;
    logic       rst320;
    logic       enable;
    logic       fc;
    logic [7:0] fc_word;
    logic       fc_word_valid;
    logic       locked;
    logic [3:0] slip_cnt;
    logic [7:0] err_cnt;
    logic       cmd_idle, cmd_linkrst, cmd_bcr, cmd_sync;
    logic       cmd_l1a, cmd_l1a_cr, cmd_chginj, cmd_l1a_bcr;
    logic [7:0] dut_cmd;

    fc_word_aligner #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)) dut (
        .clk320(clk320), .rst320(rst320), .enable(enable), .fc(fc),
        .fc_word(fc_word), .fc_word_valid(fc_word_valid), .locked(locked),
        .slip_cnt(slip_cnt), .err_cnt(err_cnt),
        .cmd_idle(cmd_idle), .cmd_linkrst(cmd_linkrst), .cmd_bcr(cmd_bcr),
        .cmd_sync(cmd_sync), .cmd_l1a(cmd_l1a), .cmd_l1a_cr(cmd_l1a_cr),
        .cmd_chginj(cmd_chginj), .cmd_l1a_bcr(cmd_l1a_bcr)
    );

    assign dut_cmd = {cmd_idle, cmd_linkrst, cmd_bcr, cmd_sync,
                      cmd_l1a, cmd_l1a_cr, cmd_chginj, cmd_l1a_bcr};

    always #5 clk320 = ~clk320;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_err(input int n);
`ifdef FC_ERRCNT_EN
        return (n > 255) ? 255 : n;
`else
        return 0 * n;
`endif
    endfunction

    function automatic logic [7:0] cmd_of(input logic [7:0] w);
        case (w)
            8'hF0:   return 8'h80;
            8'h33:   return 8'h40;
            8'h5A:   return 8'h20;
            8'h55:   return 8'h10;
            8'h96:   return 8'h08;
            8'h66:   return 8'h04;
            8'h69:   return 8'h02;
            8'h99:   return 8'h01;
            default: return 8'h00;
        endcase
    endfunction

    // Word-level reference: bits since reset are kept in a queue, a countdown
    // of enabled bits marks the next word end, and each word runs the lock rules.
    int         m_rem, m_good, m_bad, m_slip, m_err;
    bit         m_locked, m_valid;
    logic [7:0] m_word, m_cmd;
    bit         bitq[$];

    task automatic model_word(input logic [7:0] w, output bit slipped);
        slipped = 0;
        m_word  = w;
        m_valid = 1;
        if (!m_locked) begin
            if (w == 8'hF0) begin
                m_good++;
                if (m_good == LOCK_CNT) begin
                    m_locked = 1;
                    m_bad    = 0;
                    m_cmd    = cmd_of(w);
                end
            end else begin
                m_good  = 0;
                slipped = 1;
                if (m_slip < 15) m_slip++;
            end
        end else if (cmd_of(w) != 8'h00) begin
            m_bad = 0;
            m_cmd = cmd_of(w);
        end else begin
            m_bad++;
            m_err = exp_err(m_err + 1);
            if (m_bad == UNLOCK_CNT) begin
                m_locked = 0;
                m_good   = 0;
                m_bad    = 0;
            end
        end
    endtask

    task automatic model_edge(input bit rst, input bit en, input bit b);
        logic [7:0] w;
        bit slipped;
        if (rst) begin
            m_rem = 8; m_good = 0; m_bad = 0; m_slip = 0; m_err = 0;
            m_locked = 0; m_valid = 0; m_word = 8'h00; m_cmd = 8'h00;
            bitq.delete();
        end else if (!en) begin
            m_valid = 0;
            m_cmd   = 8'h00;
        end else begin
            m_valid = 0;
            m_cmd   = 8'h00;
            bitq.push_back(b);
            if (bitq.size() > 8) void'(bitq.pop_front());
            m_rem--;
            if (m_rem == 0) begin
                w = 8'h00;
                foreach (bitq[i]) w = {w[6:0], bitq[i]};
                model_word(w, slipped);
                m_rem = slipped ? 7 : 8;
            end
        end
    endtask

    task automatic compare_all();
        chk("model_valid",  fc_word_valid, m_valid);
        chk("model_word",   fc_word,       m_word);
        chk("model_cmd",    dut_cmd,       m_cmd);
        chk("model_locked", locked,        m_locked);
        chk("model_slip",   slip_cnt,      m_slip);
        chk("model_err",    err_cnt,       m_err);
    endtask

    task automatic step(input bit b, input bit en);
        fc     = b;
        enable = en;
        @(posedge clk320);
        model_edge(rst320, en, b);
        #1;
        compare_all();
    endtask

    task automatic do_reset(input bit en);
        rst320 = 1'b1;
        step(1'b1, en);
        chk("rst_word",   fc_word, 0);
        chk("rst_valid",  fc_word_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_slip",   slip_cnt, 0);
        chk("rst_err",    err_cnt, 0);
        chk("rst_cmd",    dut_cmd, 0);
        rst320 = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) step(w[i], 1'b1);
    endtask

    typedef struct {
        logic [7:0] word;
        logic [7:0] exp_cmd;
        logic       exp_locked;
        int         exp_errc;
    } vec_t;

    vec_t vt[15];
    logic [7:0] codes[8];
    logic [7:0] idle_w;
    bit stream[$];

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{8'h96, 8'h08, 1'b1, exp_err(0)};
        vt[1]  = '{8'h5A, 8'h20, 1'b1, exp_err(0)};
        vt[2]  = '{8'h33, 8'h40, 1'b1, exp_err(0)};
        vt[3]  = '{8'h55, 8'h10, 1'b1, exp_err(0)};
        vt[4]  = '{8'h66, 8'h04, 1'b1, exp_err(0)};
        vt[5]  = '{8'h69, 8'h02, 1'b1, exp_err(0)};
        vt[6]  = '{8'h99, 8'h01, 1'b1, exp_err(0)};
        vt[7]  = '{8'h00, 8'h00, 1'b1, exp_err(1)};
        vt[8]  = '{8'h00, 8'h00, 1'b1, exp_err(2)};
        vt[9]  = '{8'h00, 8'h00, 1'b1, exp_err(3)};
        vt[10] = '{8'hF0, 8'h80, 1'b1, exp_err(3)};
        vt[11] = '{8'h00, 8'h00, 1'b1, exp_err(4)};
        vt[12] = '{8'h00, 8'h00, 1'b1, exp_err(5)};
        vt[13] = '{8'h00, 8'h00, 1'b1, exp_err(6)};
        vt[14] = '{8'h00, 8'h00, 1'b0, exp_err(7)};
        codes  = '{8'hF0, 8'h33, 8'h5A, 8'h55, 8'h96, 8'h66, 8'h69, 8'h99};
        idle_w = 8'hF0;

        rst320 = 1'b1; enable = 1'b0; fc = 1'b0;
        #12;
        do_reset(1'b1);

        // Aligned IDLE stream: lock on the 128th bit after reset.
        for (int n = 0; n < 15; n++) send_word(idle_w);
        for (int i = 7; i >= 1; i--) step(idle_w[i], 1'b1);
        chk("prelock_locked", locked, 0);
        step(idle_w[0], 1'b1);
        chk("lock_locked", locked, 1);
        chk("lock_cmd_idle", cmd_idle, 1);
        chk("lock_slip", slip_cnt, 0);
        for (int n = 0; n < 2; n++) begin
            for (int i = 7; i >= 0; i--) begin
                step(idle_w[i], 1'b1);
                chk("idle_pulse", cmd_idle, (i == 0) ? 1 : 0);
            end
        end

        // Command and invalid-word table while locked.
        foreach (vt[i]) begin
            send_word(vt[i].word);
            chk("tbl_valid",  fc_word_valid, 1);
            chk("tbl_word",   fc_word, vt[i].word);
            chk("tbl_cmd",    dut_cmd, vt[i].exp_cmd);
            chk("tbl_locked", locked, vt[i].exp_locked);
            chk("tbl_err",    err_cnt, vt[i].exp_errc);
        end
        chk("unlock_noslip", slip_cnt, 0);
        send_word(8'h00);
        chk("search_slip", slip_cnt, 1);

        // IDLE stream offset by 3 bits: three slips, then 16 IDLEs.
        do_reset(1'b1);
        stream = '{1, 0, 0, 0, 0};
        for (int n = 0; n < 20; n++)
            for (int i = 7; i >= 0; i--) stream.push_back(idle_w[i]);
        foreach (stream[s]) begin
            step(stream[s], 1'b1);
            if (s == 147) chk("off_prelock", locked, 0);
            if (s == 148) begin
                chk("off_lock", locked, 1);
                chk("off_slip", slip_cnt, 3);
                chk("off_idle", cmd_idle, 1);
            end
            if (s == 155) chk("off_gap", fc_word_valid, 0);
            if (s == 156) chk("off_next", cmd_idle, 1);
        end

        // Reset mid-word while locked (enable low: reset must still win).
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        do_reset(1'b0);
        for (int n = 0; n < 15; n++) send_word(idle_w);
        for (int i = 7; i >= 1; i--) step(idle_w[i], 1'b1);
        chk("relock_pre", locked, 0);
        step(idle_w[0], 1'b1);
        chk("relock", locked, 1);

        // Enable low for 5 cycles mid-word while locked.
        for (int i = 7; i >= 5; i--) step(idle_w[i], 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'($urandom_range(0, 1)), 1'b0);
            chk("dis_valid", fc_word_valid, 0);
            chk("dis_cmd", dut_cmd, 0);
        end
        for (int i = 4; i >= 0; i--) step(idle_w[i], 1'b1);
        chk("en_valid", fc_word_valid, 1);
        chk("en_idle", cmd_idle, 1);
        chk("en_locked", locked, 1);
        chk("en_slip", slip_cnt, 0);

        // slip_cnt saturation.
        do_reset(1'b1);
        for (int n = 0; n < 20; n++) send_word(8'h00);
        chk("slip_sat", slip_cnt, 15);

        // err_cnt saturation while staying locked.
        do_reset(1'b1);
        for (int n = 0; n < 16; n++) send_word(idle_w);
        for (int g = 0; g < 90; g++) begin
            send_word(8'h00); send_word(8'h00); send_word(8'h00); send_word(idle_w);
        end
        chk("err_sat", err_cnt, exp_err(270));
        chk("err_sat_locked", locked, 1);

        // Randomized streams against the model.
        for (int run = 0; run < 3; run++) begin
            do_reset(1'b1);
            for (int k = $urandom_range(0, 7); k > 0; k--) step(1'($urandom_range(0, 1)), 1'b1);
            for (int n = 0; n < 32; n++) send_word(idle_w);
            chk("rand_lock", locked, 1);
            for (int n = 0; n < 250; n++) begin
                logic [7:0] w;
                int r;
                r = $urandom_range(0, 9);
                w = (r < 8) ? codes[r] : 8'($urandom_range(0, 255));
                for (int i = 7; i >= 0; i--) begin
                    if ($urandom_range(0, 15) == 0)
                        for (int d = $urandom_range(1, 3); d > 0; d--)
                            step(1'($urandom_range(0, 1)), 1'b0);
                    step(w[i], 1'b1);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
